button_event: RTL and testbench

BUTTON_EVENT -- requirements
Module: button_event

---
 rtl/button_event.sv | 171 +++++++++++++++++
 tb/tb_button_event.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// rtl/button_event.sv - press/repeat/release event generator for a debounced auto-repeating button
// Optional long-press detection is enabled with macro BTN_LONGPRESS_EN.
module button_event #(
    parameter logic [29:0] GAP_LIMIT  = 30'd5200000,
    parameter logic [7:0]  LONG_COUNT = 8'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [1:0] evt_code,
    output logic [7:0] evt_count,
    output logic       overflow,
    output logic       long_press
);

    localparam logic [1:0] CODE_PRESS   = 2'b01;
    localparam logic [1:0] CODE_REPEAT  = 2'b10;
    localparam logic [1:0] CODE_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        hit_q;
    logic        rise;
    logic        fall;
    logic [29:0] gap_cnt;
    logic [7:0]  rep_cnt;
    logic [7:0]  rep_cnt_nxt;
    logic        gap_hit;
    logic        gap_clr;
    logic        gap_inc;
    logic        gen_valid;
    logic [1:0]  gen_code;
    logic [7:0]  gen_count;
    logic        gen_release;

    assign rise    = hit && !hit_q;
    assign fall    = !hit && hit_q;
    assign gap_hit = (gap_cnt == GAP_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In GAP a rising edge takes priority over a timeout reached in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (rise) state_nxt = DOWN;
            DOWN: if (fall) state_nxt = GAP;
            GAP: begin
                if (rise) begin
                    state_nxt = DOWN;
                end else if (gap_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gen_valid   = 1'b0;
        gen_code    = 2'b00;
        gen_count   = rep_cnt;
        gen_release = 1'b0;
        rep_cnt_nxt = rep_cnt;
        gap_clr     = 1'b0;
        gap_inc     = 1'b0;
        case (state)
            IDLE: begin
                rep_cnt_nxt = 8'd0;
                gap_clr     = 1'b1;
                if (rise) begin
                    gen_valid = 1'b1;
                    gen_code  = CODE_PRESS;
                    gen_count = 8'd0;
                end
            end
            DOWN: begin
                if (fall) begin
                    gap_clr = 1'b1;
                end
            end
            GAP: begin
                if (rise) begin
                    rep_cnt_nxt = (rep_cnt == 8'hFF) ? rep_cnt : rep_cnt + 8'd1;
                    gen_valid   = 1'b1;
                    gen_code    = CODE_REPEAT;
                    gen_count   = rep_cnt_nxt;
                end else if (gap_hit) begin
                    gen_valid   = 1'b1;
                    gen_code    = CODE_RELEASE;
                    gen_count   = rep_cnt;
                    gen_release = 1'b1;
                    rep_cnt_nxt = 8'd0;
                end else if (!hit) begin
                    gap_inc = 1'b1;
                end
            end
            default: begin
                rep_cnt_nxt = 8'd0;
                gap_clr     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q   <= 1'b0;
            gap_cnt <= 30'd0;
            rep_cnt <= 8'd0;
        end else begin
            hit_q   <= hit;
            rep_cnt <= rep_cnt_nxt;
            if (gap_clr) begin
                gap_cnt <= 30'd0;
            end else if (gap_inc) begin
                gap_cnt <= gap_cnt + 30'd1;
            end
        end
    end

    // A held event is never overwritten unless it is being accepted this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_code  <= 2'b00;
            evt_count <= 8'd0;
            overflow  <= 1'b0;
        end else begin
            if (gen_valid && (!evt_valid || evt_ready)) begin
                evt_valid <= 1'b1;
                evt_code  <= gen_code;
                evt_count <= gen_count;
            end else if (gen_valid) begin
                overflow  <= 1'b1;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

`ifdef BTN_LONGPRESS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_press <= 1'b0;
        end else if (gen_release) begin
            long_press <= 1'b0;
        end else if (rep_cnt >= LONG_COUNT) begin
            long_press <= 1'b1;
        end
    end
`else
    logic unused_long;
    assign unused_long = gen_release ^ (^LONG_COUNT);
    assign long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// tb/tb_button_event.sv - self-checking bench for button_event against a behavioural model
module tb_button_event;

    localparam int GL = 20;
    localparam int LC = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hit = 1'b0;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [1:0] evt_code;
    logic [7:0] evt_count;
    logic       overflow;
    logic       long_press;

    int errors = 0;
    int checks = 0;

    logic [9:0] log_q[$];
    logic [9:0] exp_q[$];

    // Model: whether the button is held, consecutive low cycles since the fall,
    // repeat count, and the contents of the output register.
    logic       m_prev;
    logic       m_held;
    int         m_low;
    int         m_cnt;
    logic       m_valid;
    logic [1:0] m_code;
    logic [7:0] m_count;
    logic       m_ovf;
    logic       m_lp;

    button_event #(
        .GAP_LIMIT (30'd20),
        .LONG_COUNT(8'd3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit       (hit),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_count (evt_count),
        .overflow  (overflow),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = 1'b0;
        m_held  = 1'b0;
        m_low   = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_code  = 2'b00;
        m_count = 8'd0;
        m_ovf   = 1'b0;
        m_lp    = 1'b0;
    endtask

    task automatic model_step();
        logic       gen;
        logic       rel;
        logic [1:0] gc;
        int         gn;
        int         pre_cnt;
        gen     = 1'b0;
        rel     = 1'b0;
        gc      = 2'b00;
        gn      = 0;
        pre_cnt = m_cnt;
        if (!m_held) begin
            if (hit && !m_prev) begin
                gen = 1'b1; gc = 2'b01; gn = 0;
                m_held = 1'b1; m_low = 0;
            end
        end else if (hit && !m_prev) begin
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            gen = 1'b1; gc = 2'b10; gn = m_cnt;
            m_low = 0;
        end else if (!hit) begin
            m_low++;
            // fall cycle counts as 1; timeout once GL further low cycles have elapsed
            if (m_low == GL + 2) begin
                gen = 1'b1; gc = 2'b11; gn = m_cnt; rel = 1'b1;
                m_cnt = 0; m_held = 1'b0; m_low = 0;
            end
        end else begin
            m_low = 0;
        end
`ifdef BTN_LONGPRESS_EN
        if (rel) m_lp = 1'b0;
        else if (pre_cnt >= LC) m_lp = 1'b1;
`else
        m_lp = 1'b0;
`endif
        if (gen) begin
            if (!m_valid || evt_ready) begin
                m_valid = 1'b1; m_code = gc; m_count = gn[7:0];
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && evt_ready) begin
            m_valid = 1'b0;
        end
        m_prev = hit;
    endtask

    task automatic cyc(input logic h, input logic r);
        @(negedge clk);
        hit = h;
        evt_ready = r;
        if (evt_valid && evt_ready) log_q.push_back({evt_code, evt_count});
        @(posedge clk);
        model_step();
        #1;
        chk("evt_valid", evt_valid, m_valid);
        chk("evt_code", evt_code, m_code);
        chk("evt_count", evt_count, m_count);
        chk("overflow", overflow, m_ovf);
        chk("long_press", long_press, m_lp);
    endtask

    task automatic pulses(input int nh, input int nl, input logic r);
        repeat (nh) cyc(1'b1, r);
        repeat (nl) cyc(1'b0, r);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_n"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk(tag, log_q[i], exp_q[i]);
        end
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int first;
        int len;
        logic lvl;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_code", evt_code, 2'b00);
        chk("rst_count", evt_count, 8'd0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_lp", long_press, 1'b0);
        #1;
        rst_n = 1'b1;

        // single press then timeout
        log_q.delete();
        repeat (10) cyc(1'b1, 1'b1);
        first = -1;
        for (int i = 0; i < 25; i++) begin
            cyc(1'b0, 1'b1);
            if (first < 0 && evt_valid && evt_code == 2'b11) first = i;
        end
        chk("rel_latency", first, 21);
        exp_q = '{10'h100, 10'h300};
        check_log("single");

        // four pulses then timeout
        repeat (4) pulses(5, 10, 1'b1);
        repeat (25) cyc(1'b0, 1'b1);
        exp_q = '{10'h100, 10'h201, 10'h202, 10'h203, 10'h303};
        check_log("repeat4");

        // rise exactly when the gap counter hits the limit wins
        pulses(5, 21, 1'b1);
        pulses(5, 25, 1'b1);
        exp_q = '{10'h100, 10'h201, 10'h301};
        check_log("gap_edge");

        // one cycle later the timeout happens first
        pulses(5, 22, 1'b1);
        pulses(5, 25, 1'b1);
        exp_q = '{10'h100, 10'h300, 10'h100, 10'h300};
        check_log("gap_late");

        // consumer stalled: PRESS held, REPEATs dropped
        pulses(5, 10, 1'b0);
        pulses(5, 10, 1'b0);
        chk("stall_code", evt_code, 2'b01);
        chk("stall_count", evt_count, 8'd0);
        chk("stall_ovf", overflow, 1'b1);
        repeat (30) cyc(1'b0, 1'b1);
        chk("ovf_sticky", overflow, 1'b1);
        log_q.delete();

        // reset asynchronously mid-gap with an event pending
        pulses(5, 5, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", evt_valid, 1'b0);
        chk("arst_code", evt_code, 2'b00);
        chk("arst_count", evt_count, 8'd0);
        chk("arst_ovf", overflow, 1'b0);
        chk("arst_lp", long_press, 1'b0);
        hit = 1'b1;
        evt_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        cyc(1'b1, 1'b1);
        chk("post_rst_code", evt_code, 2'b01);
        chk("post_rst_valid", evt_valid, 1'b1);
        repeat (4) cyc(1'b1, 1'b1);
        repeat (25) cyc(1'b0, 1'b1);
        log_q.delete();

        // randomized runs against the model
        lvl = 1'b0;
        for (int k = 0; k < 120; k++) begin
            lvl = ~lvl;
            len = lvl ? $urandom_range(1, 8) : $urandom_range(1, 26);
            for (int j = 0; j < len; j++) begin
                cyc(lvl, ($urandom_range(0, 7) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
